// File: rtl/cdc_pkg.sv
// cdc_pkg: shared state type and defaults for the four-phase handshake source
package cdc_pkg;
  typedef enum logic [1:0] {IDLE, REQ_HI, WAIT_LO} cdc_hs_state_e;
  localparam int CDC_HS_TIMEOUT_DEF = 1024;
endpackage

// File: rtl/cdc_sync_2ff.sv
// cdc_sync_2ff: two-flop level synchroniser with asynchronous active-low clear
module cdc_sync_2ff (
  input  logic clock,
  input  logic arst_n,
  input  logic din,
  output logic dout
);
  logic meta;
  always_ff @(posedge clock or negedge arst_n)
    if (!arst_n) {dout, meta} <= 2'b00;
    else {dout, meta} <= {meta, din};
endmodule

// File: rtl/cdc_hs_src.sv
// cdc_hs_src: four-phase req/ack source side; CDC_HS_TIMEOUT_EN adds a per-phase watchdog
module cdc_hs_src
  import cdc_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = CDC_HS_TIMEOUT_DEF
) (
  input  logic              clock,
  input  logic              arst,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
  output logic              src_ready,
  output logic              req_o,
  output logic [DATA_W-1:0] data_o,
  input  logic              ack_i,
  output logic              done_o,
  output logic              err_o
);
  cdc_hs_state_e state;
  logic ack_s;
  cdc_sync_2ff u_ack_sync (
    .clock (clock),
    .arst_n(~arst),
    .din   (ack_i),
    .dout  (ack_s)
  );
  assign src_ready = state == IDLE && !ack_s;
`ifdef CDC_HS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC);
  logic [CW-1:0] cnt;
  logic tmo;
  assign tmo = state != IDLE && cnt == CW'(TIMEOUT_CYC - 1);
`else
  assign err_o = 1'b0;
`endif
  always_ff @(posedge clock or posedge arst)
    if (arst) begin
      state  <= IDLE;
      req_o  <= 1'b0;
      data_o <= '0;
      done_o <= 1'b0;
`ifdef CDC_HS_TIMEOUT_EN
      err_o  <= 1'b0;
      cnt    <= '0;
`endif
    end else begin
      done_o <= 1'b0;
`ifdef CDC_HS_TIMEOUT_EN
      err_o  <= 1'b0;
      cnt    <= (state == IDLE) ? '0 : cnt + 1'b1;
      if (tmo) begin
        state <= IDLE;
        req_o <= 1'b0;
        err_o <= 1'b1;
        cnt   <= '0;
      end else
`endif
      case (state)
        IDLE:
          if (src_valid && src_ready) begin
            data_o <= src_data;
            req_o  <= 1'b1;
            state  <= REQ_HI;
          end
        REQ_HI:
          if (ack_s) begin
            req_o <= 1'b0;
            state <= WAIT_LO;
`ifdef CDC_HS_TIMEOUT_EN
            cnt   <= '0;
`endif
          end
        WAIT_LO:
          if (!ack_s) begin
            state  <= IDLE;
            done_o <= 1'b1;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_cdc_hs_src.sv
// tb_cdc_hs_src: randomized handshake bench against a timing-rule and scoreboard model
module tb_cdc_hs_src;
  localparam int DW  = 8;
  localparam int TMO = 16;
  logic clock = 1'b0, arst = 1'b1, src_valid = 1'b0, ack_i = 1'b0;
  logic src_ready, req_o, done_o, err_o;
  logic [DW-1:0] src_data = '0, data_o;
  int n_tests = 0, n_fail = 0;
  int done_cnt = 0, err_cnt = 0, exp_done = 0, exp_err = 0;
  logic [DW-1:0] sent[$], seen[$];
  logic req_prev = 1'b0;

  cdc_hs_src #(.DATA_W(DW), .TIMEOUT_CYC(TMO)) dut (
    .clock    (clock),
    .arst     (arst),
    .src_valid(src_valid),
    .src_data (src_data),
    .src_ready(src_ready),
    .req_o    (req_o),
    .data_o   (data_o),
    .ack_i    (ack_i),
    .done_o   (done_o),
    .err_o    (err_o)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (done_o) done_cnt++;
    if (err_o) err_cnt++;
    if (req_o && !req_prev) seen.push_back(data_o);
    req_prev = req_o;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start(input logic [DW-1:0] d, input bit hold);
    int n = 0;
    while (!src_ready && n < 40) begin
      tick();
      n++;
    end
    check("ready_wait", 32'(n < 40), 1);
    src_valid = 1'b1;
    src_data  = d;
    sent.push_back(d);
    tick();
    src_valid = hold;
    src_data  = ~d;
    check("req_rise", req_o, 1);
    check("data_load", data_o, d);
    check("ready_busy", src_ready, 0);
  endtask

  task automatic xfer(input logic [DW-1:0] d, input bit hold);
    int dh = $urandom_range(2, 10);
    int dl = $urandom_range(2, 10);
    start(d, hold);
    repeat (dh) begin
      tick();
      check("req_hold", req_o, 1);
      check("data_hold", data_o, d);
      check("ready_busy", src_ready, 0);
    end
    ack_i = 1'b1;
    repeat (2) begin
      tick();
      check("req_sync", req_o, 1);
    end
    tick();
    check("req_fall", req_o, 0);
    check("data_keep", data_o, d);
    repeat (dl) begin
      tick();
      check("no_done", done_o, 0);
      check("ready_ack", src_ready, 0);
    end
    ack_i = 1'b0;
    src_valid = 1'b0;
    repeat (2) begin
      tick();
      check("done_early", done_o, 0);
    end
    tick();
    check("done_pulse", done_o, 1);
    exp_done++;
    tick();
    check("done_one", done_o, 0);
    check("ready_b2b", src_ready, 1);
  endtask

  initial begin
    repeat (3) tick();
    check("rst_req", req_o, 0);
    check("rst_data", data_o, 0);
    check("rst_done", done_o, 0);
    check("rst_err", err_o, 0);
    check("rst_ready", src_ready, 1);
    arst = 1'b0;
    tick();
    check("rel_req", req_o, 0);
    check("rel_done", done_o, 0);

    xfer(8'hA5, 1'b0);
    xfer(DW'($urandom), 1'b1);
    for (int i = 0; i < 10; i++) xfer(DW'(i), 1'($urandom_range(0, 1)));

    start(8'h3C, 1'b0);
    tick();
    tick();
    arst = 1'b1;
    #1;
    check("mid_rst_req", req_o, 0);
    check("mid_rst_data", data_o, 0);
    check("mid_rst_done", done_o, 0);
    check("mid_rst_err", err_o, 0);
    #2 arst = 1'b0;
    tick();
    check("mid_rel_req", req_o, 0);
    check("mid_rel_ready", src_ready, 1);

    arst  = 1'b1;
    ack_i = 1'b1;
    repeat (3) tick();
    arst = 1'b0;
    tick();
    tick();
    repeat (4) begin
      tick();
      check("stale_ready", src_ready, 0);
    end
    ack_i = 1'b0;
    tick();
    check("stale_still", src_ready, 0);
    tick();
    check("stale_clear", src_ready, 1);

`ifdef CDC_HS_TIMEOUT_EN
    start(8'h5A, 1'b0);
    repeat (TMO - 1) begin
      tick();
      check("tmo_req", req_o, 1);
      check("tmo_err0", err_o, 0);
    end
    tick();
    check("tmo_err", err_o, 1);
    check("tmo_req0", req_o, 0);
    check("tmo_idle", src_ready, 1);
    exp_err++;
    tick();
    check("tmo_err_one", err_o, 0);
`else
    start(8'h5A, 1'b0);
    repeat (100) begin
      tick();
      check("notmo_req", req_o, 1);
      check("notmo_err", err_o, 0);
    end
    ack_i = 1'b1;
    repeat (3) tick();
    check("late_req_fall", req_o, 0);
    ack_i = 1'b0;
    repeat (3) tick();
    check("late_done", done_o, 1);
    exp_done++;
    tick();
`endif

    repeat (4) xfer(DW'($urandom), 1'($urandom_range(0, 1)));
    repeat (3) tick();

    check("done_total", done_cnt, exp_done);
    check("err_total", err_cnt, exp_err);
    check("seq_len", seen.size(), sent.size());
    for (int i = 0; i < sent.size() && i < seen.size(); i++) check("seq_data", seen[i], sent[i]);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
